uart_tx_mmio: RTL
=================

Name: uart_tx_mmio

Overview:
- Memory-mapped serial transmitter on the CPU memory bus, alongside the memory block.
- Consumes CPU stores aimed at its address window and buffers bytes in a small FIFO.
- Serialises each byte onto txd as 8N1 frames.
- Stalls the CPU through clkHold when a store arrives while the FIFO is full; never drops data.

Parameters:
- BASE_ADDR, 16'hFF00: word address of DATA; STATUS is at BASE_ADDR+1.
- FIFO_DEPTH, 4: byte entries, power of two, minimum 2.
- CLKS_PER_BIT, 16: clk cycles per serial bit, minimum 2.

Ports:
- clk  in  1  system clock, all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- memAddr  in  16  CPU memory address
- memRe  in  1  CPU read strobe
- memWe  in  1  CPU write strobe
- memWBus  in  16  CPU write data; bits [7:0] used
- memRBus  out  16  read data; 0 unless a read hits the window
- sel  out  1  high when memAddr is BASE_ADDR or BASE_ADDR+1; top level uses it to mux memRBus
- clkHold  out  1  CPU stall request
- txd  out  1  serial output, idle high

Behaviour:
- Reset, asynchronous on rst low:
  - txd=1, clkHold=0, memRBus=0.
  - FIFO emptied; FSM in IDLE; baud and bit counters cleared.
  - Applies immediately even mid-frame; a partial frame is abandoned and txd goes high.
- Address decode and read data (combinational):
  - sel = (memAddr==BASE_ADDR) or (memAddr==BASE_ADDR+1).
  - Read of STATUS (memRe & addr BASE_ADDR+1): memRBus = {8'h0, 1'b0, count[2:0], 1'b0, busy, full, empty}.
  - count saturates at 7 in the field. busy=1 whenever FSM is not IDLE.
  - Read of DATA returns 16'h0000.
- Push:
  - On the rising edge where memWe & addr==BASE_ADDR & !full, memWBus[7:0] is pushed.
  - Writes to STATUS and writes outside the window are ignored.
- clkHold (combinational) = memWe & (memAddr==BASE_ADDR) & full.
  - While asserted no push occurs. The CPU holds the bus; the push completes on the first edge after full deasserts.
- Full/empty:
  - Derived from a registered count (0..FIFO_DEPTH).
  - Push and pop on the same edge leave count unchanged.
  - A pop in the current cycle does not release clkHold until the next cycle, so there is no combinational path from FSM to clkHold.
- FSM, states IDLE, START, DATA, STOP; baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - IDLE: txd=1. If !empty: pop the head into an 8-bit shift register, go to START, clear the baud counter.
  - START: txd=0. At baud==CLKS_PER_BIT-1 go to DATA with bit index 0.
  - DATA: txd=shift[0], LSB first. At baud end, shift right and increment the index. After index 7 go to STOP.
  - STOP: txd=1. At baud end: if !empty pop and go directly to START (back-to-back, no idle gap); else go to IDLE.
- Latency:
  - Store accepted at edge N: FIFO non-empty after N, pop and START at edge N+1, txd low from N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Simultaneous events:
  - Read and write in the same cycle are handled independently.
  - STATUS read during a push shows pre-edge values.
- Pointers: read/write pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}
  - localparams DATA_OFS=0, STATUS_OFS=1
  - STATUS bit positions EMPTY_BIT=0, FULL_BIT=1, BUSY_BIT=2, COUNT_LSB=4
- One sub-module, sync_fifo (WIDTH, DEPTH): push, pop, din, dout, full, empty, count; same clk/rst convention.
- FSM, baud counter and decode stay in uart_tx_mmio.

Test Plan:
- Reset then idle 50 cycles -> txd=1, clkHold=0, STATUS read = 16'h0001.
- Write 16'h1255 to FF00, CLKS_PER_BIT=16 -> txd low from the edge after the write for 16 cycles, then bits 1,0,1,0,1,0,1,0, then stop high; total 160 cycles; busy=0 afterwards.
- Write A1,A2,A3 back-to-back -> three contiguous frames, 480 cycles with no idle gap; STATUS count reads 2 immediately after the third write (first already popped).
- Write 6 bytes with FIFO_DEPTH=4 -> clkHold asserts on the 6th write (1 in shift register + 4 queued). It stays high until the first frame's STOP pops, then the push lands; all 6 bytes appear on txd in order.
- Assert rst mid-DATA of frame 1 with 2 bytes queued -> txd=1 asynchronously, STATUS=16'h0001 after release, no further frames.
- Write to FF01, write to FF02, read FF00 -> no push, sel=0 for FF02, memRBus=0 for the FF00 read.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
// Imported by the FIFO and the transmitter top.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [15:0] DATA_OFS   = 16'd0;
  localparam logic [15:0] STATUS_OFS = 16'd1;

  localparam int EMPTY_BIT = 0;
  localparam int FULL_BIT  = 1;
  localparam int BUSY_BIT  = 2;
  localparam int COUNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Full/empty come from the count, so they never glitch on pointer wrap.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic doPush;
  logic doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      unique case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with byte FIFO and CPU stall on full.
// DATA at BASE_ADDR, STATUS at BASE_ADDR+1.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] memAddr,
  input  logic        memRe,
  input  logic        memWe,
  input  logic [15:0] memWBus,
  output logic [15:0] memRBus,
  output logic        sel,
  output logic        clkHold,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  tx_state_t state;
  logic [BW-1:0] baud;
  logic [2:0]    bitIdx;
  logic [7:0]    shift;

  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  logic hitData;
  logic hitStatus;
  logic push;
  logic pop;
  logic baudEnd;
  logic busy;
  logic [2:0]  cntField;
  logic [31:0] cntWide;
  logic [15:0] status;

  assign hitData   = (memAddr == BASE_ADDR + DATA_OFS);
  assign hitStatus = (memAddr == BASE_ADDR + STATUS_OFS);
  assign sel       = hitData | hitStatus;

  assign push    = memWe & hitData & ~full;
  assign clkHold = memWe & hitData & full;

  assign baudEnd = (baud == BW'(CLKS_PER_BIT - 1));
  assign busy    = (state != IDLE);
  assign pop     = ~empty & ((state == IDLE) |
                   ((state == STOP) & baudEnd));

  assign cntWide  = 32'(count);
  assign cntField = (cntWide > 32'd7) ? 3'd7 : cntWide[2:0];

  always_comb begin
    status = '0;
    status[EMPTY_BIT] = empty;
    status[FULL_BIT]  = full;
    status[BUSY_BIT]  = busy;
    status[COUNT_LSB +: 3] = cntField;
  end

  assign memRBus = (memRe & hitStatus) ? status : 16'h0000;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (memWBus[7:0]),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  // txd is registered and updated on the edge that enters each bit period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      baud   <= '0;
      bitIdx <= '0;
      shift  <= '0;
      txd    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          txd  <= 1'b1;
          baud <= '0;
          if (!empty) begin
            shift <= head;
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (baudEnd) begin
            baud   <= '0;
            bitIdx <= '0;
            state  <= DATA;
            txd    <= shift[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baudEnd) begin
            baud   <= '0;
            shift  <= shift >> 1;
            bitIdx <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              txd <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baudEnd) begin
            baud <= '0;
            if (!empty) begin
              shift <= head;
              state <= START;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
